// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debouncing.
// Drives one column low at a time and reports a stable key_press level plus key_code.
module keypad_scanner #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_press,
    output logic [3:0] key_code
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t        state, next_state;
    logic [3:0]    row_meta, row_s;
    logic [DW-1:0] dwell_cnt;
    logic [BW-1:0] deb_cnt;
    logic [1:0]    col_idx, row_idx, low_idx;
    logic          single_low, all_high, row_match, dwell_done, deb_done;

    function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Rows are asynchronous pad inputs; only row_s is ever used downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta <= 4'b1111;
            row_s    <= 4'b1111;
        end else begin
            row_meta <= row_in;
            row_s    <= row_meta;
        end
    end

    always_comb begin
        single_low = 1'b1;
        low_idx    = 2'd0;
        case (row_s)
            4'b1110: low_idx = 2'd0;
            4'b1101: low_idx = 2'd1;
            4'b1011: low_idx = 2'd2;
            4'b0111: low_idx = 2'd3;
            default: single_low = 1'b0;
        endcase
    end

    assign all_high   = (row_s == 4'b1111);
    assign row_match  = (row_s == ~(4'b0001 << row_idx));
    assign dwell_done = (dwell_cnt == DWELL_LAST);
    assign deb_done   = (deb_cnt == DEB_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= SCAN;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            SCAN:     if (dwell_done && single_low) next_state = DEBOUNCE;
            DEBOUNCE: if (!row_match)               next_state = SCAN;
                      else if (deb_done)            next_state = PRESSED;
            PRESSED:  if (all_high)                 next_state = RELEASE;
            RELEASE:  if (!all_high)                next_state = PRESSED;
                      else if (deb_done)            next_state = SCAN;
            default:                                next_state = SCAN;
        endcase
    end

    // Counters only increment below their last value, so they saturate rather than wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            key_press <= 1'b0;
            key_code  <= 4'h0;
        end else begin
            case (state)
                SCAN: begin
                    if (dwell_done) begin
                        dwell_cnt <= '0;
                        if (single_low) begin
                            row_idx <= low_idx;
                            deb_cnt <= '0;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + DW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!row_match) begin
                        dwell_cnt <= '0;
                        deb_cnt   <= '0;
                    end else if (deb_done) begin
                        key_press <= 1'b1;
                        key_code  <= map_key(row_idx, col_idx);
                    end else begin
                        deb_cnt <= deb_cnt + BW'(1);
                    end
                end
                PRESSED: begin
                    if (all_high) deb_cnt <= '0;
                end
                RELEASE: begin
                    if (!all_high) begin
                        deb_cnt <= '0;
                    end else if (deb_done) begin
                        key_press <= 1'b0;
                        col_idx   <= col_idx + 2'd1;
                        dwell_cnt <= '0;
                        deb_cnt   <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + BW'(1);
                    end
                end
                default: begin
                    dwell_cnt <= '0;
                    deb_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        col_out = ~(4'b0001 << col_idx);
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model reacts to col_out, a scoreboard
// checks key_code on every key_press rise, and hand sequences cover timing corner cases.
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;

    logic       clk, rst;
    logic [3:0] row_in, col_out, key_code;
    logic       key_press;

    logic       key_held, override_en;
    logic [1:0] key_row, key_col;
    logic [3:0] override_val, keypad_rows;

    int errors, checks, cyc, rise_cnt, fall_cnt;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [1:0] row;
        logic [1:0] col;
        logic [3:0] code;
    } vec_t;
    vec_t vecs[16];

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
        .key_press(key_press), .key_code(key_code)
    );

    // A held key pulls its row low only while its column is being driven.
    always_comb begin
        keypad_rows = 4'b1111;
        if (key_held && col_out[key_col] == 1'b0) keypad_rows[key_row] = 1'b0;
    end
    assign row_in = override_en ? override_val : keypad_rows;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic held, input logic [1:0] r, input logic [1:0] c,
                                 input logic [3:0] code);
        key_held = held;
        key_row  = r;
        key_col  = c;
        if (held) exp_q.push_back(code);
    endtask

    task automatic waitLevel(input logic level, input int max, input string name, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < max; i++) begin
            if (key_press == level) begin
                at_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (at_cyc < 0) begin
            errors++;
            $display("[TB] FAIL %s: key_press never reached %0d within %0d cycles", name, level, max);
        end
    endtask

    task automatic waitCol(input logic [3:0] pattern, input int max, input string name, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < max; i++) begin
            if (col_out == pattern) begin
                at_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (at_cyc < 0) begin
            errors++;
            $display("[TB] FAIL %s: col_out never became %b within %0d cycles", name, pattern, max);
        end
    endtask

    task automatic monitor();
        logic       prev;
        logic [3:0] expected;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (key_press && !prev) begin
                rise_cnt++;
                if (exp_q.size() > 0) begin
                    expected = exp_q.pop_front();
                    checkOutput("key_code at press", key_code, expected);
                end else begin
                    checkOutput("pending presses at rise", exp_q.size(), 1);
                end
            end
            if (!key_press && prev) fall_cnt++;
            prev = key_press;
        end
    endtask

    initial begin
        int p0, r, b, n, bad, kp_hi, changes, r0, f0;
        logic [3:0] prev_col, col12, exp_col;

        errors = 0; checks = 0; rise_cnt = 0; fall_cnt = 0;
        rst = 1'b0; key_held = 1'b0; key_row = 2'd0; key_col = 2'd0;
        override_en = 1'b0; override_val = 4'b1111;

        vecs[0]  = '{2'd0, 2'd0, 4'h1}; vecs[1]  = '{2'd0, 2'd1, 4'h2};
        vecs[2]  = '{2'd0, 2'd2, 4'h3}; vecs[3]  = '{2'd0, 2'd3, 4'hA};
        vecs[4]  = '{2'd1, 2'd0, 4'h4}; vecs[5]  = '{2'd1, 2'd1, 4'h5};
        vecs[6]  = '{2'd1, 2'd2, 4'h6}; vecs[7]  = '{2'd1, 2'd3, 4'hB};
        vecs[8]  = '{2'd2, 2'd0, 4'h7}; vecs[9]  = '{2'd2, 2'd1, 4'h8};
        vecs[10] = '{2'd2, 2'd2, 4'h9}; vecs[11] = '{2'd2, 2'd3, 4'hC};
        vecs[12] = '{2'd3, 2'd0, 4'hE}; vecs[13] = '{2'd3, 2'd1, 4'h0};
        vecs[14] = '{2'd3, 2'd2, 4'hF}; vecs[15] = '{2'd3, 2'd3, 4'hD};

        fork monitor(); join_none

        repeat (3) @(negedge clk);
        checkOutput("reset col_out", col_out, 4'b1110);
        checkOutput("reset key_press", key_press, 0);
        checkOutput("reset key_code", key_code, 4'h0);
        rst = 1'b1;

        // Key 5: row_s lags the pins by 2, so the press lands 12 clocks after column 1 starts.
        applyStimulus(1'b1, 2'd1, 2'd1, 4'h5);
        waitCol(4'b1101, 20, "reach column 1", p0);
        waitLevel(1'b1, 40, "press 5", r);
        checkOutput("press 5 latency", r - p0, 12);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (col_out != 4'b1101) bad++;
        end
        checkOutput("column held during 5", bad, 0);
        checkOutput("key_press held during 5", key_press, 1);
        applyStimulus(1'b0, 2'd0, 2'd0, 4'h0);
        waitLevel(1'b0, 40, "release 5", r);

        $display("[TB] glitch during column 3");
        waitCol(4'b0111, 40, "reach column 3", p0);
        override_en = 1'b1;
        override_val = 4'b1110;
        bad = 0; kp_hi = 0; col12 = 4'b0000;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 5) override_val = 4'b1111;
            if (k <= 11 && col_out != 4'b0111) bad++;
            if (k == 12) col12 = col_out;
            if (key_press) kp_hi++;
        end
        checkOutput("column 3 held through aborted debounce", bad, 0);
        checkOutput("wrap to column 0 after abort", col12, 4'b1110);
        checkOutput("no press on glitch", kp_hi, 0);
        override_en = 1'b0;

        $display("[TB] # press with bouncy release");
        r0 = rise_cnt; f0 = fall_cnt;
        applyStimulus(1'b1, 2'd3, 2'd2, 4'hF);
        waitLevel(1'b1, 40, "press #", r);
        checkOutput("column held during #", col_out, 4'b1011);
        key_held = 1'b0;
        override_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            override_val = 4'b1111;
            repeat (2) @(negedge clk);
            override_val = 4'b0111;
            repeat (2) @(negedge clk);
        end
        override_val = 4'b1111;
        b = cyc;
        waitLevel(1'b0, 30, "release #", r);
        checkOutput("release # latency", r - b, 11);
        repeat (2) @(negedge clk);
        checkOutput("single rise for #", rise_cnt - r0, 1);
        checkOutput("single fall for #", fall_cnt - f0, 1);

        $display("[TB] two rows low in one column");
        override_val = 4'b1010;
        repeat (4) @(negedge clk);
        prev_col = col_out; changes = 0; bad = 0; kp_hi = 0;
        repeat (32) begin
            @(negedge clk);
            if (col_out != prev_col) begin
                changes++;
                if (col_out != {prev_col[2:0], prev_col[3]}) bad++;
            end
            if (key_press) kp_hi++;
            prev_col = col_out;
        end
        checkOutput("column changes with two rows low", changes, 8);
        checkOutput("rotation order", bad, 0);
        checkOutput("no press with two rows low", kp_hi, 0);
        override_en = 1'b0;

        $display("[TB] reset while 0 is held");
        applyStimulus(1'b1, 2'd3, 2'd1, 4'h0);
        waitLevel(1'b1, 40, "press 0", r);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("key_press drops in reset", key_press, 0);
        checkOutput("col_out in reset", col_out, 4'b1110);
        @(negedge clk);
        rst = 1'b1;
        n = cyc;
        exp_q.push_back(4'h0);
        waitLevel(1'b1, 40, "re-press 0", r);
        checkOutput("re-press 0 latency", r - n, 16);
        applyStimulus(1'b0, 2'd0, 2'd0, 4'h0);
        waitLevel(1'b0, 40, "release 0", r);

        $display("[TB] 7 then 3");
        r0 = rise_cnt;
        applyStimulus(1'b1, 2'd2, 2'd0, 4'h7);
        waitLevel(1'b1, 40, "press 7", r);
        repeat (5) @(negedge clk);
        applyStimulus(1'b0, 2'd0, 2'd0, 4'h0);
        waitLevel(1'b0, 40, "release 7", r);
        applyStimulus(1'b1, 2'd0, 2'd2, 4'h3);
        waitLevel(1'b1, 40, "press 3", r);
        repeat (5) @(negedge clk);
        applyStimulus(1'b0, 2'd0, 2'd0, 4'h0);
        waitLevel(1'b0, 40, "release 3", r);
        repeat (10) @(negedge clk);
        checkOutput("key_code holds 3", key_code, 4'h3);
        checkOutput("two presses for 7 then 3", rise_cnt - r0, 2);

        $display("[TB] full key map");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, vecs[i].row, vecs[i].col, vecs[i].code);
            waitLevel(1'b1, 40, $sformatf("table press %0d", i), r);
            exp_col = ~(4'b0001 << vecs[i].col);
            checkOutput($sformatf("table key %0d col_out", i), col_out, exp_col);
            checkOutput($sformatf("table key %0d code", i), key_code, vecs[i].code);
            repeat (3) @(negedge clk);
            applyStimulus(1'b0, 2'd0, 2'd0, 4'h0);
            waitLevel(1'b0, 40, $sformatf("table release %0d", i), r);
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
